// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory controller: FSM states,
// data access width encodings and the IO region selector.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    DREAD  = 2'd2,
    DWRITE = 2'd3
  } state_e;

  localparam logic [1:0] WIDTH_B = 2'b00;
  localparam logic [1:0] WIDTH_H = 2'b01;
  localparam logic [1:0] WIDTH_W = 2'b10;

  localparam logic [1:0] IO_BASE_HI = 2'b11;

  localparam int unsigned CNT_W = 3;

  // Illegal width 2'b11 is treated as a word.
  function automatic logic [CNT_W-1:0] width_to_bytes(input logic [1:0] width);
    case (width)
      WIDTH_B: return CNT_W'(1);
      WIDTH_H: return CNT_W'(2);
      WIDTH_W: return CNT_W'(4);
      default: return CNT_W'(4);
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates the icache byte-fetch port and the load/store data port onto a
// byte-wide, 1-cycle-latency RAM/IO bus; data accesses move one byte per cycle.
module mem_ctrl #(
  parameter logic [1:0] IO_BASE_HI = mem_ctrl_pkg::IO_BASE_HI
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memory_get_en,
  input  logic [16:0] memory_addr,
  output logic        memory_out_en,
  output logic [7:0]  memory_content,
  input  logic        data_req_en,
  input  logic        data_we,
  input  logic [1:0]  data_width,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_done,
  output logic [31:0] data_rdata,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);
  import mem_ctrl_pkg::*;

  state_e           state;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [CNT_W-1:0] nbytes_q;
  logic [CNT_W-1:0] issue_q;
  logic [CNT_W-1:0] recv_q;

  logic             data_win_c;
  logic             fetch_sel_c;
  logic             issuing_c;
  logic             stall_c;
  logic [31:0]      cur_addr_c;

  assign memory_content = mem_din;

  // Bus drive: icache address while fetching, current data byte otherwise.
  always_comb begin
    data_win_c  = data_req_en && !data_done;
    fetch_sel_c = (state == IFETCH) || (state == IDLE && !data_win_c && memory_get_en);
    issuing_c   = issue_q < nbytes_q;
    cur_addr_c  = addr_q + 32'(issue_q);
    stall_c     = (state == DWRITE) && (cur_addr_c[17:16] == IO_BASE_HI) && io_buffer_full;
    mem_a       = '0;
    mem_wr      = 1'b0;
    mem_dout    = '0;
    if (rst) begin
      mem_a = '0;
    end else if (fetch_sel_c) begin
      mem_a = {15'b0, memory_addr};
    end else if (state == DREAD && issuing_c) begin
      mem_a = cur_addr_c;
    end else if (state == DWRITE) begin
      mem_a    = cur_addr_c;
      mem_wr   = !stall_c;
      mem_dout = 8'(wdata_q >> {issue_q, 3'b000});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      nbytes_q      <= '0;
      issue_q       <= '0;
      recv_q        <= '0;
      memory_out_en <= 1'b0;
      data_done     <= 1'b0;
      data_rdata    <= '0;
    end else begin
      memory_out_en <= 1'b0;
      data_done     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (data_win_c) begin
            state    <= data_we ? DWRITE : DREAD;
            addr_q   <= data_addr;
            wdata_q  <= data_wdata;
            nbytes_q <= width_to_bytes(data_width);
            issue_q  <= '0;
            recv_q   <= '0;
            if (!data_we) data_rdata <= '0;
          end else if (memory_get_en) begin
            state         <= IFETCH;
            memory_out_en <= 1'b1;
          end
        end
        IFETCH: begin
          if (memory_get_en) memory_out_en <= 1'b1;
          else               state         <= IDLE;
        end
        // Issue and capture overlap: byte k lands one cycle after its issue.
        DREAD: begin
          if (issuing_c) issue_q <= issue_q + CNT_W'(1);
          if (recv_q < issue_q) begin
            data_rdata <= data_rdata | (32'(mem_din) << {recv_q, 3'b000});
            recv_q     <= recv_q + CNT_W'(1);
            if (recv_q == nbytes_q - CNT_W'(1)) begin
              data_done <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        DWRITE: begin
          if (!stall_c) begin
            issue_q <= issue_q + CNT_W'(1);
            if (issue_q == nbytes_q - CNT_W'(1)) begin
              data_done <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: transaction-level model of fetch bytes, bus
// writes/reads and completions, checked every cycle by one compare process.
module tb_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        memory_get_en;
  logic [16:0] memory_addr;
  logic        memory_out_en;
  logic [7:0]  memory_content;
  logic        data_req_en;
  logic        data_we;
  logic [1:0]  data_width;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_done;
  logic [31:0] data_rdata;
  logic        io_buffer_full;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  mem_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .memory_get_en  (memory_get_en),
    .memory_addr    (memory_addr),
    .memory_out_en  (memory_out_en),
    .memory_content (memory_content),
    .data_req_en    (data_req_en),
    .data_we        (data_we),
    .data_width     (data_width),
    .data_addr      (data_addr),
    .data_wdata     (data_wdata),
    .data_done      (data_done),
    .data_rdata     (data_rdata),
    .io_buffer_full (io_buffer_full),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr)
  );

  typedef struct { int c; logic [31:0] a; logic [7:0] d; } wr_t;
  typedef struct { int c; logic rd; logic [31:0] v; } dn_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]  ram[logic [31:0]];
  logic [7:0]  ref_ram[logic [31:0]];
  logic [31:0] bus_a = 0;
  logic        bus_wr = 0;
  logic [7:0]  bus_dout = 0;

  logic [31:0] e_a[int];
  logic        e_wr[int];
  wr_t         wq[$];
  dn_t         dq[$];
  logic [7:0]  fq[$];

  int first_oe = -1;
  int last_oe = -1;
  int last_done_cyc = -1;
  logic [31:0] last_rdata = 0;

  // Icache requester: re-requests the next byte until fetch_n bytes arrived.
  logic        fetch_want = 0;
  logic [16:0] fetch_base = 0;
  int          fetch_n = 0;
  int          cnt0 = 0;
  int          oe_total = 0;
  int          rcv;
  int          io_lo = 1;
  int          io_hi = 0;

  assign rcv            = oe_total - cnt0 + int'(memory_out_en);
  assign memory_get_en  = fetch_want && (rcv < fetch_n);
  assign memory_addr    = fetch_base + 17'(rcv);
  assign io_buffer_full = (cyc >= io_lo) && (cyc <= io_hi);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (memory_out_en) oe_total <= oe_total + 1;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_ram.exists(a) ? ref_ram[a] : 8'h00;
  endfunction

  // Byte-wide RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (bus_wr) ram[bus_a] = bus_dout;
    mem_din <= ram_rd(bus_a);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: actual 0x%0h required 0x%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    bus_a    = mem_a;
    bus_wr   = mem_wr;
    bus_dout = mem_dout;
    if (rst) begin
      chk("rst mem_wr", 32'(mem_wr), 32'd0);
      chk("rst mem_a", mem_a, 32'd0);
      chk("rst mem_dout", 32'(mem_dout), 32'd0);
    end else begin
      if (e_a.exists(cyc)) chk("mem_a", mem_a, e_a[cyc]);
      if (e_wr.exists(cyc)) chk("mem_wr", 32'(mem_wr), 32'(e_wr[cyc]));
      if (memory_out_en) begin
        if (first_oe < 0) first_oe = cyc;
        last_oe = cyc;
        if (fq.size() == 0) chk("unexpected out_en", 32'(memory_out_en), 32'd0);
        else                chk("memory_content", 32'(memory_content), 32'(fq.pop_front()));
      end
      if (mem_wr) begin
        if (wq.size() == 0) chk("unexpected mem_wr", 32'(mem_wr), 32'd0);
        else begin
          wr_t w;
          w = wq.pop_front();
          chk("write cycle", 32'(cyc), 32'(w.c));
          chk("write addr", mem_a, w.a);
          chk("write data", 32'(mem_dout), 32'(w.d));
        end
      end
      if (data_done) begin
        last_done_cyc = cyc;
        last_rdata    = data_rdata;
        if (dq.size() == 0) chk("unexpected data_done", 32'(data_done), 32'd0);
        else begin
          dn_t d;
          d = dq.pop_front();
          chk("done cycle", 32'(cyc), 32'(d.c));
          if (d.rd) chk("data_rdata", data_rdata, d.v);
        end
      end
    end
  end

  function automatic int nbytes(input logic [1:0] w);
    return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] v);
    ram[a]     = v;
    ref_ram[a] = v;
  endtask

  // Read accepted at cycle t: issue in t+1..t+n, done in t+n+2.
  task automatic model_read(input int t, input logic [31:0] a, input logic [1:0] w);
    int n;
    logic [31:0] v;
    dn_t d;
    n = nbytes(w);
    v = 0;
    for (int k = 0; k < n; k++) begin
      e_a[t + 1 + k] = a + 32'(k);
      v = v | (32'(ref_rd(a + 32'(k))) << (8 * k));
    end
    d.c = t + n + 2;
    d.rd = 1'b1;
    d.v = v;
    dq.push_back(d);
  endtask

  // Write accepted at cycle t: one byte per cycle unless an IO byte meets a full buffer.
  task automatic model_write(input int t, input logic [31:0] a, input logic [1:0] w,
                             input logic [31:0] wd);
    int n;
    int k;
    int c;
    logic [31:0] ca;
    wr_t x;
    dn_t d;
    n = nbytes(w);
    k = 0;
    c = t + 1;
    while (k < n) begin
      ca = a + 32'(k);
      if (ca[17:16] == 2'b11 && c >= io_lo && c <= io_hi) begin
        e_wr[c] = 1'b0;
        e_a[c]  = ca;
      end else begin
        x.c = c;
        x.a = ca;
        x.d = wd[8*k +: 8];
        wq.push_back(x);
        ref_ram[ca] = wd[8*k +: 8];
        k++;
      end
      c++;
    end
    d.c = c;
    d.rd = 1'b0;
    d.v = 0;
    dq.push_back(d);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requester: raise the request, drop it in the cycle data_done is seen.
  task automatic run_data(input logic we, input logic [1:0] w, input logic [31:0] a,
                          input logic [31:0] wd);
    bit got;
    got = 1'b0;
    data_we = we;
    data_width = w;
    data_addr = a;
    data_wdata = wd;
    data_req_en = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (data_done) got = 1'b1;
    end
    #1;
    data_req_en = 1'b0;
    if (!got) chk("data_done timeout", 32'(data_done), 32'd1);
  endtask

  task automatic start_fetch(input logic [16:0] base, input int n);
    fetch_base = base;
    fetch_n = n;
    cnt0 = oe_total;
    first_oe = -1;
    fetch_want = 1'b1;
  endtask

  task automatic wait_fetch();
    for (int i = 0; i < 40 && rcv < fetch_n; i++) @(negedge clk);
    #1;
    if (rcv < fetch_n) chk("fetch timeout", 32'(rcv), 32'(fetch_n));
    fetch_want = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, actual running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst = 1'b1;
    data_req_en = 1'b0;
    data_we = 1'b0;
    data_width = 2'b00;
    data_addr = 0;
    data_wdata = 0;
    preload(32'h100, 8'h11); preload(32'h101, 8'h22);
    preload(32'h102, 8'h33); preload(32'h103, 8'h44);
    preload(32'h104, 8'h55); preload(32'h105, 8'h66);
    preload(32'h200, 8'h5A); preload(32'h201, 8'hA5);
    preload(32'h202, 8'hAA); preload(32'h203, 8'hBB);
    preload(32'h204, 8'hCC); preload(32'h205, 8'hDD);
    preload(32'h1003, 8'hEE);
    preload(32'hFFFFFFFF, 8'h01); preload(32'h0, 8'h02);
    preload(32'h1, 8'h03); preload(32'h2, 8'h04);

    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk); #1;
    chk("reset out_en", 32'(memory_out_en), 32'd0);
    chk("reset data_done", 32'(data_done), 32'd0);
    chk("reset data_rdata", data_rdata, 32'd0);
    chk("reset mem_a", mem_a, 32'd0);
    chk("reset mem_wr", 32'(mem_wr), 32'd0);

    // Icache line fetch of four bytes.
    tick(); t0 = cyc;
    fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33); fq.push_back(8'h44);
    for (int k = 0; k < 4; k++) e_a[t0 + k] = 32'h100 + 32'(k);
    e_a[t0 + 5] = 32'h0;
    start_fetch(17'h100, 4);
    wait_fetch();
    repeat (2) tick();
    chk("fetch first out_en", 32'(first_oe - t0), 32'd1);
    chk("fetch last out_en", 32'(last_oe - t0), 32'd4);
    chk("fetch bytes pending", 32'(fq.size()), 32'd0);

    // Word load.
    tick(); t0 = cyc;
    model_read(t0, 32'h202, 2'b10);
    run_data(1'b0, 2'b10, 32'h202, 32'h0);
    chk("word load done cycle", 32'(last_done_cyc - t0), 32'd6);
    chk("word load rdata", last_rdata, 32'hDDCCBBAA);
    repeat (2) tick();

    // Half store outside the IO region: a full IO buffer must not stall it.
    tick(); t0 = cyc;
    io_lo = t0; io_hi = t0 + 10;
    model_write(t0, 32'h1001, 2'b01, 32'h00005678);
    run_data(1'b1, 2'b01, 32'h1001, 32'h00005678);
    chk("half store done cycle", 32'(last_done_cyc - t0), 32'd3);
    io_lo = 1; io_hi = 0;
    repeat (2) tick();
    chk("byte after half store", 32'(ram_rd(32'h1003)), 32'hEE);

    // IO byte store with the buffer full for three cycles.
    tick(); t0 = cyc;
    io_lo = t0 + 1; io_hi = t0 + 3;
    model_write(t0, 32'h00030000, 2'b00, 32'h0000009A);
    run_data(1'b1, 2'b00, 32'h00030000, 32'h0000009A);
    chk("io store done cycle", 32'(last_done_cyc - t0), 32'd5);
    io_lo = 1; io_hi = 0;
    repeat (2) tick();

    // Simultaneous data and fetch requests: data first.
    tick(); t0 = cyc;
    fq.push_back(8'h5A); fq.push_back(8'hA5);
    e_a[t0] = 32'h0;
    model_read(t0, 32'h202, 2'b10);
    start_fetch(17'h200, 2);
    run_data(1'b0, 2'b10, 32'h202, 32'h0);
    wait_fetch();
    chk("contention done cycle", 32'(last_done_cyc - t0), 32'd6);
    chk("contention first out_en", 32'(first_oe - t0), 32'd7);
    repeat (2) tick();
    chk("contention bytes pending", 32'(fq.size()), 32'd0);

    // Data request raised mid-fetch waits for get_en to drop.
    tick(); t0 = cyc;
    for (int k = 0; k < 6; k++) begin
      fq.push_back(ram_rd(32'h100 + 32'(k)));
      e_a[t0 + k] = 32'h100 + 32'(k);
    end
    start_fetch(17'h100, 6);
    repeat (2) tick();
    model_read(t0 + 7, 32'h1002, 2'b00);
    run_data(1'b0, 2'b00, 32'h1002, 32'h0);
    fetch_want = 1'b0;
    chk("mid-fetch done cycle", 32'(last_done_cyc - t0), 32'd10);
    chk("mid-fetch byte rdata", last_rdata, 32'h00000056);
    chk("mid-fetch bytes pending", 32'(fq.size()), 32'd0);
    repeat (2) tick();

    // Illegal width acts as a word; address wraps past 0xFFFFFFFF.
    tick(); t0 = cyc;
    model_read(t0, 32'hFFFFFFFF, 2'b11);
    run_data(1'b0, 2'b11, 32'hFFFFFFFF, 32'h0);
    chk("wrap load rdata", last_rdata, 32'h04030201);
    chk("wrap load done cycle", 32'(last_done_cyc - t0), 32'd6);
    repeat (2) tick();

    // Reset in the middle of a read, then a fresh half load.
    tick(); t0 = cyc;
    e_a[t0 + 1] = 32'h202;
    e_a[t0 + 3] = 32'h0;
    e_wr[t0 + 3] = 1'b0;
    data_we = 1'b0; data_width = 2'b10; data_addr = 32'h202; data_req_en = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    data_req_en = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk); #1;
    chk("post-rst data_done", 32'(data_done), 32'd0);
    chk("post-rst mem_a", mem_a, 32'd0);
    chk("post-rst mem_wr", 32'(mem_wr), 32'd0);
    tick(); t0 = cyc;
    model_read(t0, 32'h202, 2'b01);
    run_data(1'b0, 2'b01, 32'h202, 32'h0);
    chk("post-rst load rdata", last_rdata, 32'h0000BBAA);
    chk("post-rst load done cycle", 32'(last_done_cyc - t0), 32'd4);
    repeat (3) tick();

    chk("writes pending", 32'(wq.size()), 32'd0);
    chk("completions pending", 32'(dq.size()), 32'd0);
    foreach (ram[k]) chk("ram contents", 32'(ram[k]), 32'(ref_rd(k)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
